// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store engine in front of a word-only data memory.
// One access at a time: IDLE -> (READ) -> (WRITE) -> RESP -> IDLE.
// Sub-word stores are done as read-modify-write because the memory has no byte enables.
// Accesses that are misaligned, use an illegal funct3 or fall outside the memory
// go straight to RESP with err set, so memory is never touched for them.
module load_store_unit #(
    parameter int unsigned DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_BYTES);

    logic [1:0]  state_q,    state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q,   funct3_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;   // store data, replaced by the merged word for SB/SH
    logic        err_q,      err_d;
    logic [31:0] rdata_q,    rdata_d;

    logic        req_err;
    logic [31:0] lane_shifted;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    // Classify the incoming request; only meaningful while IDLE.
    always_comb begin
        logic misaligned;
        logic bad_funct3;
        logic out_of_range;
        misaligned   = ((funct3[1:0] == 2'b01) && addr[0])
                    || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        if (is_store) begin
            bad_funct3 = (funct3 > 3'b010);
        end else begin
            bad_funct3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end
        out_of_range = (addr >= DMEM_LIMIT);
        req_err      = misaligned || bad_funct3 || out_of_range;
    end

    // Select the addressed lane from the fetched word and extend it.
    always_comb begin
        lane_shifted = mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_value = {{24{lane_shifted[7]}},  lane_shifted[7:0]};
            3'b001:  load_value = {{16{lane_shifted[15]}}, lane_shifted[15:0]};
            3'b100:  load_value = {24'd0, lane_shifted[7:0]};
            3'b101:  load_value = {16'd0, lane_shifted[15:0]};
            default: load_value = mem_rdata;
        endcase
    end

    // Byte-lane merge for SB/SH: each lane keeps the fetched byte unless the store covers it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge_lane
            logic sb_hit;
            logic sh_hit;
            assign sb_hit = (funct3_q == 3'b000) && (addr_q[1:0] == 2'(gi));
            assign sh_hit = (funct3_q == 3'b001) && (addr_q[1] == ((gi / 2) != 0));
            assign merged_word[gi*8 +: 8] =
                sb_hit ? wdata_q[7:0] :
                sh_hit ? ((gi % 2) != 0 ? wdata_q[15:8] : wdata_q[7:0]) :
                         mem_rdata[gi*8 +: 8];
        end
    endgenerate

    // Next-state and latch-update logic for the access sequencer.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    err_d      = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (is_store && (funct3 == 3'b010)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (is_store_q) begin
                    wdata_d = merged_word;
                    state_d = S_WRITE;
                end else begin
                    // Result becomes visible together with done in RESP.
                    rdata_d = load_value;
                    state_d = S_RESP;
                end
            end
            S_WRITE: begin
                state_d = S_RESP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latch registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Outputs come from registers only, so memory controls never see a request-input path.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_RESP);
    assign err       = (state_q == S_RESP) && err_q;
    assign rdata     = rdata_q;
    assign MemRead   = (state_q == S_READ);
    assign MemWrite  = (state_q == S_WRITE);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;

endmodule
